// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types for the memory stage.
//   - exmem_t / memwb_t : EX/MEM and MEM/WB register layouts. Datapath fields
//     are sized for the widest supported XLEN (64); a 32-bit build uses the
//     low half and keeps the upper half at zero.
//   - lsu_state_t       : load/store unit FSM states.
//   - funct3 encodings for loads and stores.
package pipeline_pkg;

    localparam int MAX_XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // funct3[1:0] is the access size (byte/half/word/double),
    // funct3[2] selects zero-extension for loads.
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef struct packed {
        logic [MAX_XLEN-1:0] ALUResult;
        logic [MAX_XLEN-1:0] WriteData;
        logic [2:0]          funct3;
        logic                MemWrite;
        logic                RegWrite;
        logic [1:0]          ResultSrc;
        logic [4:0]          Rd;
        logic [MAX_XLEN-1:0] PCPlus4;
        logic [MAX_XLEN-1:0] ImmExt;
    } exmem_t;

    typedef struct packed {
        logic [MAX_XLEN-1:0] ALUResult;
        logic [MAX_XLEN-1:0] load_data;
        logic                RegWrite;
        logic [1:0]          ResultSrc;
        logic [4:0]          Rd;
        logic [MAX_XLEN-1:0] PCPlus4;
        logic [MAX_XLEN-1:0] ImmExt;
    } memwb_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: purely combinational byte-lane logic for the memory stage.
//   funct3     : access size / extension select
//   offset     : low address bits (byte position inside the bus word)
//   is_store   : access is a store (byte enables only generated for stores)
//   wdata      : store data, right-aligned
//   rdata      : full aligned bus read word
//   misaligned : access not naturally aligned, or size illegal for XLEN
//   be         : byte enables for the bus
//   wdata_lane : store data shifted onto its byte lane
//   load_ext   : selected lane of rdata, sign/zero-extended to XLEN
module lsu_align
    import pipeline_pkg::*;
#(
    parameter int  XLEN   = 32,
    localparam int NBYTES = XLEN / 8,
    localparam int OFF_W  = $clog2(XLEN / 8)
) (
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  offset,
    input  logic              is_store,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic              misaligned,
    output logic [NBYTES-1:0] be,
    output logic [XLEN-1:0]   wdata_lane,
    output logic [XLEN-1:0]   load_ext
);

    logic [1:0]        size;
    logic              zext;
    logic [NBYTES-1:0] be_base;
    logic [XLEN-1:0]   rdata_shifted;

    always_comb begin
        size          = funct3[1:0];
        zext          = funct3[2];
        misaligned    = 1'b0;
        be_base       = '0;
        load_ext      = '0;
        rdata_shifted = rdata >> {offset, 3'b000};
        wdata_lane    = wdata << {offset, 3'b000};

        case (size)
            2'b00: begin
                be_base = NBYTES'(1);
                if (zext) load_ext = XLEN'(rdata_shifted[7:0]);
                else      load_ext = XLEN'($signed(rdata_shifted[7:0]));
            end
            2'b01: begin
                misaligned = offset[0];
                be_base    = NBYTES'(2'b11);
                if (zext) load_ext = XLEN'(rdata_shifted[15:0]);
                else      load_ext = XLEN'($signed(rdata_shifted[15:0]));
            end
            2'b10: begin
                misaligned = |offset[1:0];
                be_base    = NBYTES'(4'hF);
                if (zext) load_ext = XLEN'(rdata_shifted[31:0]);
                else      load_ext = XLEN'($signed(rdata_shifted[31:0]));
            end
            default: begin
                // Doubleword: only legal at XLEN=64 and never with the
                // zero-extend bit (there is no unsigned doubleword load).
                misaligned = (XLEN == 32) || zext || (|offset);
                be_base    = '1;
                load_ext   = rdata_shifted;
            end
        endcase

        be = is_store ? (be_base << offset) : '0;
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access pipeline stage with a variable-latency
// valid/ready data-memory port.
//   clk, rst_n           : clock, asynchronous active-low reset
//   inputs               : EX/MEM register contents
//   valid_m, mem_read_m  : instruction valid / is a load
//   flush_m              : discard the instruction in M
//   outputs, wb_valid    : MEM/WB next state and retire strobe
//   stall_m              : freeze F/D/E/M
//   misaligned_m         : misaligned access (no bus request issued)
//   RdM, RegWriteM, ALUResultM : forwarding taps
//   req_* / rsp_*        : data-memory bus
//   state_dbg            : current FSM state
//
// Bus handshake: a request transfers on a cycle where req_valid & req_ready
// are both high; while req_valid & !req_ready the request fields hold
// because the stalled EX/MEM register holds. At most one request is
// outstanding; the response is the single cycle with rsp_valid high while
// in WAIT, and rsp_valid in any other state is ignored.
module mem_stage_lsu
    import pipeline_pkg::*;
#(
    parameter int  XLEN       = 32,
    parameter int  ADDR_WIDTH = 32,
    localparam int NBYTES     = XLEN / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  exmem_t                inputs,
    input  logic                  valid_m,
    input  logic                  mem_read_m,
    input  logic                  flush_m,
    output memwb_t                outputs,
    output logic                  wb_valid,
    output logic                  stall_m,
    output logic                  misaligned_m,
    output logic [4:0]            RdM,
    output logic                  RegWriteM,
    output logic [XLEN-1:0]       ALUResultM,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_we,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [XLEN-1:0]       req_wdata,
    output logic [NBYTES-1:0]     req_be,
    input  logic                  rsp_valid,
    input  logic [XLEN-1:0]       rsp_rdata,
    output lsu_state_t            state_dbg
);

    localparam int OFF_W = $clog2(NBYTES);

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            flushed_q, flushed_d;
    logic            mem_access, mem_op, raw_misaligned;
    logic            req_valid_c, stall_c;
    logic [XLEN-1:0] load_ext, load_data_sel;
    logic            unused_wdata;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (inputs.funct3),
        .offset     (inputs.ALUResult[OFF_W-1:0]),
        .is_store   (inputs.MemWrite),
        .wdata      (inputs.WriteData[XLEN-1:0]),
        .rdata      (rsp_rdata),
        .misaligned (raw_misaligned),
        .be         (req_be),
        .wdata_lane (req_wdata),
        .load_ext   (load_ext)
    );

    // Only memory instructions can be misaligned; an ALU op whose result
    // happens to be odd must not be flagged.
    assign mem_access   = valid_m & (mem_read_m | inputs.MemWrite);
    assign mem_op       = mem_access & ~raw_misaligned;
    assign misaligned_m = rst_n & mem_access & raw_misaligned;

    assign req_we       = inputs.MemWrite;
    assign req_addr     = {inputs.ALUResult[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_wdata = ^inputs.WriteData;

    always_comb begin
        state_d       = state_q;
        rdata_d       = rdata_q;
        flushed_d     = flushed_q;
        req_valid_c   = 1'b0;
        stall_c       = 1'b0;
        load_data_sel = '0;
        case (state_q)
            IDLE: begin
                // A flush before the handshake withdraws the request.
                req_valid_c = mem_op & ~flush_m;
                stall_c     = mem_op & ~flush_m;
                flushed_d   = 1'b0;
                if (req_valid_c && req_ready) state_d = WAIT;
            end
            WAIT: begin
                stall_c = 1'b1;
                // Remember a flush seen while waiting so DONE does not retire.
                if (flush_m) flushed_d = 1'b1;
                if (rsp_valid) begin
                    rdata_d = inputs.MemWrite ? '0 : load_ext;
                    state_d = DONE;
                end
            end
            DONE: begin
                load_data_sel = rdata_q;
                flushed_d     = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdata_q   <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            flushed_q <= flushed_d;
        end
    end

    assign req_valid = rst_n & req_valid_c;
    assign stall_m   = rst_n & stall_c;
    assign wb_valid  = rst_n & valid_m & ~stall_m & ~flush_m & ~flushed_q;

    always_comb begin
        outputs           = '0;
        outputs.ALUResult = inputs.ALUResult;
        outputs.load_data = MAX_XLEN'(load_data_sel);
        outputs.RegWrite  = inputs.RegWrite & wb_valid & ~misaligned_m;
        outputs.ResultSrc = inputs.ResultSrc;
        outputs.Rd        = inputs.Rd;
        outputs.PCPlus4   = inputs.PCPlus4;
        outputs.ImmExt    = inputs.ImmExt;
    end

    assign RdM        = inputs.Rd;
    assign RegWriteM  = inputs.RegWrite;
    assign ALUResultM = inputs.ALUResult[XLEN-1:0];
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    import pipeline_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exmem_t      ex_in;
    memwb_t      wb_out;
    logic        valid_m, mem_read_m, flush_m;
    logic        wb_valid, stall_m, misaligned_m;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [31:0] ALUResultM;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    lsu_state_t  state_dbg;

    mem_stage_lsu #(.XLEN(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .inputs(ex_in), .valid_m(valid_m),
        .mem_read_m(mem_read_m), .flush_m(flush_m), .outputs(wb_out),
        .wb_valid(wb_valid), .stall_m(stall_m), .misaligned_m(misaligned_m),
        .RdM(RdM), .RegWriteM(RegWriteM), .ALUResultM(ALUResultM),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [68:0] req_exp_q[$];   // {we, addr, wdata, be}
    logic [37:0] wb_exp_q[$];    // {load_data, RegWrite, Rd}

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a bus request
    // transfer or a retiring instruction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) begin
                if (req_exp_q.size() == 0) check("req_unexpected", 72'd1, 72'd0);
                else check("req_bus", {3'b0, req_we, req_addr, req_wdata, req_be},
                           {3'b0, req_exp_q.pop_front()});
            end
            if (wb_valid) begin
                if (wb_exp_q.size() == 0) check("wb_unexpected", 72'd1, 72'd0);
                else check("wb_result", {34'b0, wb_out.load_data[31:0], wb_out.RegWrite, wb_out.Rd},
                           {34'b0, wb_exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                          input bit ld, input bit st, input bit rw, input logic [4:0] rd);
        ex_in           = '0;
        ex_in.ALUResult = {32'b0, addr};
        ex_in.WriteData = {32'b0, wdata};
        ex_in.funct3    = f3;
        ex_in.MemWrite  = st;
        ex_in.RegWrite  = rw;
        ex_in.Rd        = rd;
        ex_in.PCPlus4   = 64'h1004;
        mem_read_m      = ld;
        valid_m         = 1'b1;
    endtask

    // Runs one instruction to retirement (first cycle with stall_m low).
    // Called at posedge+1; returns at posedge+1 after the retiring cycle.
    task automatic run_op(input int rdy_wait, input int rsp_wait, input logic [31:0] rdata,
                          input bit flush_wait, output int stalls, output int reqs,
                          output int wbs, output bit saw_mis);
        int  c = 0;
        int  acc_c = 0;
        bit  acc = 0;
        bit  done = 0;
        stalls = 0; reqs = 0; wbs = 0; saw_mis = 0;
        while (!done && c < 40) begin
            req_ready = (c >= rdy_wait);
            rsp_valid = acc && (c == acc_c + rsp_wait);
            rsp_rdata = rsp_valid ? rdata : $urandom();
            flush_m   = flush_wait && acc && (c == acc_c + 1);
            @(negedge clk);
            if (c == 0) saw_mis = misaligned_m;
            if (stall_m) stalls++;
            if (wb_valid) wbs++;
            if (req_valid && req_ready) begin
                reqs++;
                acc   = 1;
                acc_c = c;
            end
            if (!stall_m) done = 1;
            @(posedge clk); #1;
            c++;
        end
        if (!done) check("op_timeout", 72'd1, 72'd0);
        valid_m = 0; mem_read_m = 0; ex_in.MemWrite = 0; flush_m = 0;
        req_ready = 0; rsp_valid = 0;
    endtask

    // ---------------- stimulus ----------------
    int  st, rq, wb;
    bit  mis;

    initial begin
        ex_in = '0; valid_m = 0; mem_read_m = 0; flush_m = 0;
        req_ready = 0; rsp_valid = 0; rsp_rdata = '0;

        // Reset: a misaligned load held at the inputs must not show through.
        set_op(32'h101, 32'h0, LW, 1, 0, 1, 5'd1);
        req_ready = 1;
        #2;
        check("rst_req_valid", 72'(req_valid), 72'd0);
        check("rst_stall", 72'(stall_m), 72'd0);
        check("rst_wb_valid", 72'(wb_valid), 72'd0);
        check("rst_misaligned", 72'(misaligned_m), 72'd0);
        check("rst_state", 72'(state_dbg), 72'(IDLE));
        @(posedge clk); #1;
        valid_m = 0; mem_read_m = 0; req_ready = 0;
        rst_n = 1;
        @(negedge clk);
        check("post_rst_stall", 72'(stall_m), 72'd0);
        check("post_rst_load_data", 72'(wb_out.load_data), 72'd0);
        @(posedge clk); #1;

        // sb 0xA5 -> 0x103, minimum latency.
        req_exp_q.push_back({1'b1, 32'h100, 32'hA500_0000, 4'b1000});
        wb_exp_q.push_back({32'h0, 1'b0, 5'd2});
        set_op(32'h103, 32'h0000_00A5, SB, 0, 1, 0, 5'd2);
        run_op(0, 1, 32'hFFFF_FFFF, 0, st, rq, wb, mis);
        check("sb_stall_cycles", 72'(st), 72'd2);
        check("sb_req_count", 72'(rq), 72'd1);

        // lh / lhu at 0x202.
        req_exp_q.push_back({1'b0, 32'h200, 32'h0, 4'b0000});
        wb_exp_q.push_back({32'hFFFF_8001, 1'b1, 5'd3});
        set_op(32'h202, 32'h0, LH, 1, 0, 1, 5'd3);
        run_op(0, 1, 32'h8001_7FFF, 0, st, rq, wb, mis);
        check("lh_stall_cycles", 72'(st), 72'd2);

        req_exp_q.push_back({1'b0, 32'h200, 32'h0, 4'b0000});
        wb_exp_q.push_back({32'h0000_8001, 1'b1, 5'd4});
        set_op(32'h202, 32'h0, LHU, 1, 0, 1, 5'd4);
        run_op(0, 1, 32'h8001_7FFF, 0, st, rq, wb, mis);

        // Misaligned lw: no request, no stall, no register write.
        wb_exp_q.push_back({32'h0, 1'b0, 5'd5});
        set_op(32'h101, 32'h0, LW, 1, 0, 1, 5'd5);
        run_op(0, 1, 32'h0, 0, st, rq, wb, mis);
        check("mis_flag", 72'(mis), 72'd1);
        check("mis_stall_cycles", 72'(st), 72'd0);
        check("mis_req_count", 72'(rq), 72'd0);

        // Long latency: ready low 3 cycles, response 4 cycles after accept.
        req_exp_q.push_back({1'b0, 32'h300, 32'h0, 4'b0000});
        wb_exp_q.push_back({32'hDEAD_BEEF, 1'b1, 5'd6});
        set_op(32'h300, 32'h0, LW, 1, 0, 1, 5'd6);
        run_op(3, 4, 32'hDEAD_BEEF, 0, st, rq, wb, mis);
        check("lat_stall_cycles", 72'(st), 72'd8);
        check("lat_req_count", 72'(rq), 72'd1);
        check("lat_wb_pulses", 72'(wb), 72'd1);

        // Byte loads from lane 1.
        req_exp_q.push_back({1'b0, 32'h304, 32'h0, 4'b0000});
        wb_exp_q.push_back({32'hFFFF_FF9C, 1'b1, 5'd7});
        set_op(32'h305, 32'h0, LB, 1, 0, 1, 5'd7);
        run_op(0, 2, 32'h0000_9C00, 0, st, rq, wb, mis);
        check("lb_stall_cycles", 72'(st), 72'd3);

        req_exp_q.push_back({1'b0, 32'h304, 32'h0, 4'b0000});
        wb_exp_q.push_back({32'h0000_009C, 1'b1, 5'd8});
        set_op(32'h305, 32'h0, LBU, 1, 0, 1, 5'd8);
        run_op(0, 2, 32'h0000_9C00, 0, st, rq, wb, mis);

        // Word and upper-halfword stores.
        req_exp_q.push_back({1'b1, 32'h400, 32'h1122_3344, 4'b1111});
        wb_exp_q.push_back({32'h0, 1'b0, 5'd0});
        set_op(32'h400, 32'h1122_3344, SW, 0, 1, 0, 5'd0);
        run_op(1, 1, 32'h5555_5555, 0, st, rq, wb, mis);
        check("sw_stall_cycles", 72'(st), 72'd3);

        req_exp_q.push_back({1'b1, 32'h400, 32'hBEEF_0000, 4'b1100});
        wb_exp_q.push_back({32'h0, 1'b0, 5'd0});
        set_op(32'h402, 32'h0000_BEEF, SH, 0, 1, 0, 5'd0);
        run_op(0, 1, 32'h0, 0, st, rq, wb, mis);

        // Flush while waiting: response absorbed, nothing retires.
        req_exp_q.push_back({1'b0, 32'h500, 32'h0, 4'b0000});
        set_op(32'h500, 32'h0, LW, 1, 0, 1, 5'd10);
        run_op(0, 3, 32'hCAFE_F00D, 1, st, rq, wb, mis);
        check("flush_wb_pulses", 72'(wb), 72'd0);
        check("flush_state_idle", 72'(state_dbg), 72'(IDLE));

        // Following ALU op (odd result, size-encoded funct3) retires at once.
        wb_exp_q.push_back({32'h0, 1'b1, 5'd9});
        set_op(32'h7, 32'h0, 3'b001, 0, 0, 1, 5'd9);
        run_op(0, 1, 32'h0, 0, st, rq, wb, mis);
        check("alu_stall_cycles", 72'(st), 72'd0);
        check("alu_misaligned", 72'(mis), 72'd0);

        // Reset pulsed during WAIT.
        req_exp_q.push_back({1'b0, 32'h600, 32'h0, 4'b0000});
        set_op(32'h600, 32'h0, LW, 1, 0, 1, 5'd12);
        req_ready = 1;
        @(posedge clk); #1;
        req_ready = 0;
        check("rstw_in_wait", 72'(state_dbg), 72'(WAIT));
        #2 rst_n = 0;
        #1;
        check("rstw_req_valid", 72'(req_valid), 72'd0);
        check("rstw_stall", 72'(stall_m), 72'd0);
        check("rstw_wb_valid", 72'(wb_valid), 72'd0);
        check("rstw_misaligned", 72'(misaligned_m), 72'd0);
        check("rstw_regwrite", 72'(wb_out.RegWrite), 72'd0);
        check("rstw_state", 72'(state_dbg), 72'(IDLE));
        @(posedge clk); #1;
        valid_m = 0; mem_read_m = 0;
        rst_n = 1;
        @(posedge clk); #1;

        req_exp_q.push_back({1'b0, 32'h0, 32'h0, 4'b0000});
        wb_exp_q.push_back({32'h1234_5678, 1'b1, 5'd11});
        set_op(32'h0, 32'h0, LW, 1, 0, 1, 5'd11);
        run_op(0, 1, 32'h1234_5678, 0, st, rq, wb, mis);
        check("post_rstw_stall_cycles", 72'(st), 72'd2);

        @(posedge clk); #1;
        check("req_queue_drained", 72'(req_exp_q.size()), 72'd0);
        check("wb_queue_drained", 72'(wb_exp_q.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised memory-access stage replacing the fixed single-cycle data-memory stage. It sits between the EX/MEM and MEM/WB pipeline registers. It drives an external valid/ready data-memory port with variable response latency, and stalls the pipeline until the access completes. It supports XLEN 32 or 64, with byte-lane write enables, load sign/zero extension and misalignment detection.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- ADDR_WIDTH, 32, bus address width; byte address, ≤ XLEN.
- NBYTES, XLEN/8, byte lanes (derived, not overridable).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inputs  in  exmem_t  EX/MEM register contents (ALUResult, WriteData, funct3, MemWrite, RegWrite, ResultSrc, Rd, PCPlus4, ImmExt).
- valid_m  in  1  instruction in M is valid.
- mem_read_m  in  1  instruction is a load.
- flush_m  in  1  discard result of instruction in M.
- outputs  out  memwb_t  MEM/WB next-state; load_data from completed access.
- wb_valid  out  1  outputs carry a retiring instruction.
- stall_m  out  1  to hazard unit; freeze F/D/E/M.
- misaligned_m  out  1  misaligned access detected; no bus request.
- RdM  out  5  inputs.Rd.
- RegWriteM  out  1  inputs.RegWrite.
- ALUResultM  out  XLEN  inputs.ALUResult, for forwarding.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts request.
- req_we  out  1  write request.
- req_addr  out  ADDR_WIDTH  ALUResult with the low log2(NBYTES) bits cleared.
- req_wdata  out  XLEN  store data shifted to its byte lane.
- req_be  out  NBYTES  byte enables; all-zero for loads.
- rsp_valid  in  1  response (load data or store ack).
- rsp_rdata  in  XLEN  read data, full aligned word.

## Operation
- mem_op = valid_m & (mem_read_m | MemWrite) & !misaligned_m.
- Misalignment rules:
  - Halfword: addr[0] must be 0.
  - Word: addr[1:0] must be 0.
  - Doubleword (XLEN=64 only): addr[2:0] must be 0.
  - funct3 011 at XLEN=32 counts as misaligned.
- FSM states IDLE, WAIT, DONE:
  - IDLE: req_valid = mem_op. If req_valid & req_ready, go to WAIT. stall_m = mem_op.
  - WAIT: req_valid = 0, stall_m = 1. On rsp_valid, capture the load-extended rsp_rdata into rdata_q and go to DONE.
  - DONE: stall_m = 0, outputs.load_data = rdata_q, then go to IDLE unconditionally. No request is issued in DONE.
- Non-memory instructions in IDLE pass through with stall_m = 0. outputs.load_data is then 0.
- Stores complete on rsp_valid (ack). rsp_rdata is ignored for stores.
- Load extension selects the byte lane using addr[log2(NBYTES)-1:0] and funct3:
  - 000/001/010/011: sign-extend.
  - 100/101/110: zero-extend.
- wb_valid = valid_m & !stall_m & !flush_m.
- outputs.RegWrite = inputs.RegWrite & wb_valid & !misaligned_m.
- All other memwb_t fields pass through unchanged.
- flush_m:
  - In WAIT: the outstanding response is still awaited and absorbed, but wb_valid = 0 in DONE.
  - In IDLE before handshake: the request is withdrawn (req_valid = 0).
- rsp_valid arriving in IDLE or DONE is ignored.

## Timing
- Reset (rst_n low):
  - State goes to IDLE; rdata_q = 0.
  - req_valid, stall_m, wb_valid and misaligned_m are forced to 0.
- Reset mid-WAIT abandons the access. The bus is responsible for dropping the response.
- Request signals are held stable while req_valid & !req_ready. Stability comes from the stalled EX/MEM register.
- Minimum memory-instruction latency (req_ready = 1 at cycle 0, rsp_valid at cycle 1):
  - Cycle 0 (IDLE): stall_m = 1.
  - Cycle 1 (WAIT): stall_m = 1.
  - Cycle 2 (DONE): stall_m = 0.
  - Total: 2 stall cycles, result on outputs in cycle 2.
- Each cycle req_ready is low adds 1 stall cycle. Each cycle rsp_valid is low in WAIT adds 1 stall cycle.
- One outstanding request maximum.
- The misaligned path is combinational with zero stall. misaligned_m is valid in the same cycle as the inputs.

## Structure
- pipeline_pkg additions:
  - lsu_state_t enum {IDLE, WAIT, DONE}.
  - funct3 constants LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD.
  - Field layouts of exmem_t/memwb_t are unchanged.
- One combinational sub-module, lsu_align #(XLEN), holding misalignment detection, req_be generation, store lane shift and load extension. The FSM and rdata_q live in mem_stage_lsu.

## Test plan
- XLEN=32, sb 0xA5 to addr 0x103, ready=1, ack next cycle -> req_be=1000, req_wdata=0xA5000000, req_addr=0x100, stall_m high 2 cycles.
- lh at addr 0x202, rsp_rdata=0x80017FFF -> load_data=0xFFFF8001. lhu at the same address -> 0x00008001.
- lw at addr 0x101 -> misaligned_m=1, req_valid never asserts, stall_m=0, outputs.RegWrite=0.
- Load with req_ready low 3 cycles and rsp 4 cycles after accept -> stall_m high exactly 8 cycles, one request, one wb_valid pulse.
- flush_m asserted in WAIT -> response absorbed, wb_valid=0, FSM back in IDLE. A following add retires with no stall.
- rst_n pulsed low during WAIT -> all outputs 0 immediately. After release, a new lw at 0x0 with rsp 0x12345678 returns 0x12345678.
